neopixel_driver: RTL and testbench

- Consumer end of the pixel load/send handshake: accepts load_color writes of one 8-bit colour channel for one pixel into an internal frame buffer.
- On send_it, serialises the whole buffer onto neo_data with WS2812 one-wire timing, then holds the line low for the latch/reset interval.
- Reports progress through ready_to_load, ready_to_send, begin_send, done_send and done_wait. Sits between the pattern producer FSM and the LED strip pin.

---
 rtl/neopixel_pkg.sv | 35 +++
 rtl/neo_bit_encoder.sv | 54 +++++
 rtl/neopixel_driver.sv | 134 +++++++++++++
 tb/tb_neopixel_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and default WS2812 timing (cycles at 50 MHz) for the neopixel driver.
package neopixel_pkg;

  typedef enum logic [1:0] {
    RED   = 2'b00,
    GREEN = 2'b01,
    BLUE  = 2'b10
  } colour_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  localparam int NUM_PIXELS   = 5;
  localparam int T_BIT        = 63;
  localparam int T0H          = 18;
  localparam int T1H          = 35;
  localparam int RESET_CYCLES = 2600;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Position of a channel inside a pixel's 24-bit word: strip wants G, R, B.
  function automatic int slot_of(input colour_t c);
    case (c)
      GREEN:   return 0;
      RED:     return 1;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// One WS2812 bit period: bit_start arms a T_BIT-cycle period, waveform is registered
// (one cycle behind bit_cnt); bit_done marks the last cycle. No backpressure.
module neo_bit_encoder #(
  parameter int T_BIT = neopixel_pkg::T_BIT,
  parameter int T0H   = neopixel_pkg::T0H,
  parameter int T1H   = neopixel_pkg::T1H
) (
  input  logic clock,
  input  logic reset,
  input  logic bit_start,
  input  logic bit_val,
  output logic bit_wave,
  output logic bit_done
);
  import neopixel_pkg::*;

  localparam int BW = cnt_w(T_BIT);

  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          run_q, run_d;
  logic          wave_q, wave_d;

  always_comb begin
    bit_done  = run_q && (bit_cnt_q == BW'(T_BIT - 1));
    run_d     = run_q;
    bit_cnt_d = bit_cnt_q;
    // A new period may begin on the same cycle the previous one finishes.
    if (bit_start) begin
      run_d     = 1'b1;
      bit_cnt_d = '0;
    end else if (bit_done) begin
      run_d     = 1'b0;
      bit_cnt_d = '0;
    end else if (run_q) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
    end
    wave_d = run_q && (bit_cnt_q < (bit_val ? BW'(T1H) : BW'(T0H)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      run_q     <= 1'b0;
      wave_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      run_q     <= run_d;
      wave_q    <= wave_d;
    end
  end

  assign bit_wave = wave_q;

endmodule

// File: rtl/neopixel_driver.sv
// Frame buffer plus IDLE/SEND/WAIT sequencer for a WS2812 strip; first bit rises two
// cycles after send_it. Loads and sends are refused (ready_* low) outside IDLE.
module neopixel_driver #(
  parameter int NUM_PIXELS   = neopixel_pkg::NUM_PIXELS,
  parameter int T_BIT        = neopixel_pkg::T_BIT,
  parameter int T0H          = neopixel_pkg::T0H,
  parameter int T1H          = neopixel_pkg::T1H,
  parameter int RESET_CYCLES = neopixel_pkg::RESET_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_color,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send,
  output logic       begin_send,
  output logic       done_send,
  output logic       done_wait
);
  import neopixel_pkg::*;

  localparam int FRAME_BITS = NUM_PIXELS * 24;
  localparam int FB_W       = cnt_w(FRAME_BITS);
  localparam int WAIT_W     = cnt_w(RESET_CYCLES);

  if (!(T0H < T1H && T1H < T_BIT && RESET_CYCLES >= 1)) begin : g_bad_timing
    $error("neopixel_driver: need T0H < T1H < T_BIT and RESET_CYCLES >= 1");
  end

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FB_W-1:0]       frame_bit_q, frame_bit_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  begin_q, begin_d;
  logic                  done_send_q, done_send_d;
  logic                  bit_start, bit_val, bit_done, bit_wave;
  logic                  wr_ok;
  int                    wr_base;

  // Buffer is held in transmit order, so the serialiser just walks frame_bit.
  always_comb begin
    wr_ok   = load_color && (int'(pixel_index) < NUM_PIXELS) && (color_index != 2'b11);
    wr_base = int'(pixel_index) * 24 + slot_of(colour_t'(color_index)) * 8;

    state_d     = state_q;
    frame_d     = frame_q;
    frame_bit_d = frame_bit_q;
    wait_cnt_d  = wait_cnt_q;
    bit_start   = 1'b0;
    begin_d     = 1'b0;
    done_send_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          for (int i = 0; i < 8; i++) begin
            frame_d[FB_W'(wr_base + i)] = color_level[7-i];
          end
        end
        if (send_it) begin
          state_d     = SEND;
          frame_bit_d = '0;
          bit_start   = 1'b1;
          begin_d     = 1'b1;
        end
      end
      SEND: begin
        if (bit_done) begin
          if (frame_bit_q == FB_W'(FRAME_BITS - 1)) begin
            state_d     = WAIT;
            wait_cnt_d  = '0;
            done_send_d = 1'b1;
          end else begin
            frame_bit_d = frame_bit_q + FB_W'(1);
            bit_start   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_W'(RESET_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      frame_bit_q <= '0;
      wait_cnt_q  <= '0;
      begin_q     <= 1'b0;
      done_send_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      frame_bit_q <= frame_bit_d;
      wait_cnt_q  <= wait_cnt_d;
      begin_q     <= begin_d;
      done_send_q <= done_send_d;
    end
  end

  assign bit_val = frame_q[frame_bit_q];

  neo_bit_encoder #(
    .T_BIT(T_BIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_enc (
    .clock    (clock),
    .reset    (reset),
    .bit_start(bit_start),
    .bit_val  (bit_val),
    .bit_wave (bit_wave),
    .bit_done (bit_done)
  );

  assign neo_data      = bit_wave;
  assign ready_to_load = (state_q == IDLE);
  assign ready_to_send = (state_q == IDLE);
  assign begin_send    = begin_q;
  assign done_send     = done_send_q;
  assign done_wait     = (state_q == WAIT) && (wait_cnt_q == WAIT_W'(RESET_CYCLES - 1));

endmodule

// File: tb/tb_neopixel_driver.sv
// Drives loads and frames into neopixel_driver and decodes neo_data against a pixel/channel model.
module tb_neopixel_driver;

  localparam int NP        = 5;
  localparam int TB        = 63;
  localparam int T0        = 18;
  localparam int T1        = 35;
  localparam int RC        = 2600;
  localparam int FB        = NP * 24;
  localparam int FRAME_CYC = FB * TB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_color = 1'b0;
  logic [2:0] pixel_index = '0;
  logic [1:0] color_index = '0;
  logic [7:0] color_level = '0;
  logic       send_it = 1'b0;
  logic       neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait;

  neopixel_driver dut (
    .clock        (clock),
    .reset        (reset),
    .load_color   (load_color),
    .pixel_index  (pixel_index),
    .color_index  (color_index),
    .color_level  (color_level),
    .send_it      (send_it),
    .neo_data     (neo_data),
    .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send),
    .begin_send   (begin_send),
    .done_send    (done_send),
    .done_wait    (done_wait)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  logic [7:0] mdl [8][4];   // [pixel][colour code 0=R 1=G 2=B]
  logic       cap_bits [FB];
  logic       prev_bits [FB];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strip order: pixel 0 first, then G, R, B bytes, each MSB first.
  function automatic logic exp_bit(input int f);
    int p, k, ch;
    p  = f / 24;
    k  = f % 24;
    ch = (k < 8) ? 1 : ((k < 16) ? 0 : 2);
    return mdl[p][ch][7 - (k % 8)];
  endfunction

  task automatic clear_model();
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 4; c++) mdl[p][c] = 8'h00;
  endtask

  // Write strobe held for one edge; consecutive calls give back-to-back writes.
  task automatic load(input int p, input int c, input int lvl);
    @(negedge clock);
    load_color  = 1'b1;
    send_it     = 1'b0;
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = 8'(lvl);
    if (p < NP && c != 3) mdl[p][c] = 8'(lvl);
  endtask

  task automatic do_send(input string name, input bit co_load, input int load_at, input int abort_at);
    int highs, wave_err, wait_hi, busy, ds_n, ds_at, dw_n, dw_at, bs_n, k, j, th;
    logic eb, exp_hi;
    highs = 0; wave_err = 0; wait_hi = 0; busy = 0;
    ds_n = 0; ds_at = -1; dw_n = 0; dw_at = -1; bs_n = 0;

    @(negedge clock);
    chk({name, " rdy_send"}, int'(ready_to_send), 1);
    send_it    = 1'b1;
    load_color = co_load;
    if (co_load) begin
      pixel_index = 3'd3;
      color_index = 2'd1;
      color_level = 8'h80;
      mdl[3][1]   = 8'h80;
    end
    @(negedge clock);
    send_it    = 1'b0;
    load_color = 1'b0;
    chk({name, " begin_send"}, int'(begin_send), 1);
    chk({name, " rdy_load@A+1"}, int'(ready_to_load), 0);
    chk({name, " neo@A+1"}, int'(neo_data), 0);

    for (int c = 0; c < FRAME_CYC + RC; c++) begin
      @(negedge clock);
      if (c == abort_at) begin
        chk({name, " neo pre-abort"}, int'(neo_data), 1);
        reset = 1'b1;
        #1;
        chk({name, " neo on reset"}, int'(neo_data), 0);
        clear_model();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk({name, " rdy_load after reset"}, int'(ready_to_load), 1);
        chk({name, " rdy_send after reset"}, int'(ready_to_send), 1);
        return;
      end
      if (c < FRAME_CYC) begin
        k      = c / TB;
        j      = c % TB;
        eb     = exp_bit(k);
        th     = eb ? T1 : T0;
        exp_hi = (j < th);
        if (neo_data !== exp_hi) wave_err++;
        if (neo_data) highs++;
        if (j == TB - 1) begin
          chk($sformatf("%s bit%0d high cycles", name, k), highs, th);
          cap_bits[k] = (highs == T1);
          highs = 0;
        end
      end else if (neo_data) begin
        wait_hi++;
      end
      if (c < FRAME_CYC + RC - 1 && (ready_to_load || ready_to_send)) busy++;
      if (done_send) begin ds_n++; ds_at = c; end
      if (done_wait) begin dw_n++; dw_at = c; end
      if (begin_send) bs_n++;
      // Writes and sends offered mid-frame must be ignored.
      if (c == load_at) begin
        load_color  = 1'b1;
        send_it     = 1'b1;
        pixel_index = 3'd1;
        color_index = 2'd0;
        color_level = 8'h10;
      end else begin
        load_color = 1'b0;
        send_it    = 1'b0;
      end
    end
    chk({name, " waveform errors"}, wave_err, 0);
    chk({name, " neo high in wait"}, wait_hi, 0);
    chk({name, " ready while busy"}, busy, 0);
    chk({name, " done_send count"}, ds_n, 1);
    chk({name, " done_send cycle"}, ds_at, FRAME_CYC - 1);
    chk({name, " done_wait count"}, dw_n, 1);
    chk({name, " done_wait cycle"}, dw_at, FRAME_CYC + RC - 2);
    chk({name, " extra begin_send"}, bs_n, 0);
    chk({name, " rdy_send after wait"}, int'(ready_to_send), 1);
    chk({name, " rdy_load after wait"}, int'(ready_to_load), 1);
  endtask

  initial begin
    int diffs;
    clear_model();
    #1 reset = 1'b1;
    #2;
    chk("reset neo", int'(neo_data), 0);
    chk("reset rdy_load", int'(ready_to_load), 1);
    chk("reset rdy_send", int'(ready_to_send), 1);
    chk("reset begin_send", int'(begin_send), 0);
    chk("reset done_send", int'(done_send), 0);
    chk("reset done_wait", int'(done_wait), 0);
    @(negedge clock);
    reset = 1'b0;

    do_send("zero", 1'b0, -1, -1);

    load(0, 1, 8'h20);
    do_send("green", 1'b0, -1, -1);
    chk("green bit2", int'(cap_bits[2]), 1);
    chk("green bit1", int'(cap_bits[1]), 0);

    load(0, 1, 8'h00);
    load(4, 2, 8'h05);
    load(5, 0, 8'hFF);
    load(2, 3, 8'hFF);
    do_send("p4blue", 1'b0, 300, -1);
    chk("p4blue bit117", int'(cap_bits[117]), 1);
    chk("p4blue bit118", int'(cap_bits[118]), 0);
    chk("p4blue bit119", int'(cap_bits[119]), 1);
    chk("p4blue bit24", int'(cap_bits[24]), 0);

    for (int i = 0; i < FB; i++) prev_bits[i] = cap_bits[i];
    do_send("resend", 1'b0, -1, -1);
    diffs = 0;
    for (int i = 0; i < FB; i++) if (prev_bits[i] !== cap_bits[i]) diffs++;
    chk("resend frame differs", diffs, 0);

    for (int i = 0; i < 10; i++)
      load($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
    load(1, 2, 8'h11);
    load(1, 2, 8'h22);
    do_send("coload", 1'b1, -1, -1);
    chk("coload bit72", int'(cap_bits[72]), 1);

    do_send("abort", 1'b0, -1, 40 * TB + 5);
    do_send("postreset", 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
